// File: rtl/conv2_fetch_pkg.sv
// conv2_fetch_pkg
//   Shared types and constants for the conv2 kernel weight fetch block.
//   - ADDR_W / DATA_W : default ROM address and word widths
//   - SKID_DEPTH      : beats held between the ROM and the MAC array
//   - fetch_state_e   : fetch sequencer states
//   - beat_t          : one 2-word beat plus its tags
package conv2_fetch_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data0;
        logic [DATA_W-1:0] data1;
        logic              data1_vld;
        logic              last;
    } beat_t;

endpackage

// File: rtl/conv2_fetch_skid.sv
// conv2_fetch_skid
//   Two-entry FIFO of beats between the ROM read port and the weight stream.
//   Entry 0 is always the head, so the head outputs come straight from a
//   register and only change on a pop or on a push into an empty buffer.
// Ports
//   clock, reset_n  : clock, asynchronous active-low reset
//   push_i          : write push_beat_i this cycle
//   push_beat_i     : beat to write
//   pop_i           : head consumed this cycle (ignored when empty)
//   head_o          : oldest beat held
//   count_o         : number of beats held (0..2)
module conv2_fetch_skid
    import conv2_fetch_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push_i,
    input  beat_t      push_beat_i,
    input  logic       pop_i,
    output beat_t      head_o,
    output logic [1:0] count_o
);

    beat_t      e0_q, e0_d;
    beat_t      e1_q, e1_d;
    logic [1:0] count_q, count_d;
    logic       pop;

    // The fetch credit rule keeps push from ever arriving with two entries
    // held and no pop in the same cycle.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        pop     = pop_i && (count_q != 2'd0);
        case ({push_i, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    e0_d = push_beat_i;
                end else begin
                    e1_d = push_beat_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    e0_d = push_beat_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_beat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = e0_q;
    assign count_o = count_q;

endmodule

// File: rtl/conv2_kernel_fetch.sv
// conv2_kernel_fetch
//   Reads KERNEL_LEN consecutive weights from the dual-port conv2 kernel ROM
//   (1-cycle registered read) starting at base_addr and streams them as
//   2-word beats to the MAC array over valid/ready.
// Ports
//   clock, reset_n         : clock, asynchronous active-low reset
//   start, base_addr       : fetch request (sampled in IDLE) and first address
//   busy, done             : fetch in progress / 1-cycle completion pulse
//   rom_addr_a, rom_addr_b : ROM addresses of the even / odd word of a pair
//   rom_q_a, rom_q_b       : ROM read data, valid the cycle after the address
//   w_valid, w_ready       : beat handshake
//   w_data0, w_data1       : words at pair address +0 / +1
//   w_data1_vld            : low only on the short final beat of an odd kernel
//   w_last                 : final beat of the kernel
module conv2_kernel_fetch
    import conv2_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = conv2_fetch_pkg::ADDR_W,
    parameter int unsigned DATA_W     = conv2_fetch_pkg::DATA_W,
    parameter int unsigned KERNEL_LEN = 25
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr_a,
    output logic [ADDR_W-1:0] rom_addr_b,
    input  logic [DATA_W-1:0] rom_q_a,
    input  logic [DATA_W-1:0] rom_q_b,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data0,
    output logic [DATA_W-1:0] w_data1,
    output logic              w_data1_vld,
    output logic              w_last
);

    // One extra bit so a full 2**ADDR_W kernel length fits.
    localparam int unsigned       REM_W = ADDR_W + 1;
    localparam logic [REM_W-1:0]  LEN   = REM_W'(KERNEL_LEN);
    localparam logic [REM_W-1:0]  TWO   = REM_W'(2);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              infl_q, infl_d;
    logic              infl_vld1_q, infl_vld1_d;
    logic              infl_last_q, infl_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              start_ok;
    logic              issue;
    logic [2:0]        occ;
    logic [ADDR_W-1:0] pair_addr;
    logic [REM_W-1:0]  words;
    logic              pair_vld1;
    logic              pair_last;

    beat_t             cap_beat;
    beat_t             head;
    logic [1:0]        count;

    // Issue decision. The start cycle itself issues the first pair so the
    // first beat is valid two cycles after start. A beat leaving this cycle
    // frees its slot in time for the pair issued now, which is what allows
    // one beat per cycle with only two buffer entries.
    always_comb begin
        accept    = w_valid && w_ready;
        occ       = 3'(count) + 3'(infl_q) - 3'(accept);
        start_ok  = (state_q == IDLE) && start;
        issue     = start_ok || ((state_q == FETCH) && (occ < 3'(SKID_DEPTH)));
        pair_addr = start_ok ? base_addr : cur_q;
        words     = start_ok ? LEN : rem_q;
        pair_vld1 = (words >= TWO);
        pair_last = (words <= TWO);
    end

    // The ROM registers its address at the end of the issue cycle, so the
    // issued address is presented combinationally; otherwise hold the last.
    assign rom_addr_a = issue ? pair_addr : addr_a_q;
    assign rom_addr_b = issue ? (pair_addr + ADDR_W'(1)) : addr_b_q;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        infl_d      = issue;
        infl_vld1_d = infl_vld1_q;
        infl_last_d = infl_last_q;
        done_d      = 1'b0;

        if (issue) begin
            cur_d       = pair_addr + ADDR_W'(2);
            rem_d       = pair_last ? '0 : (words - TWO);
            addr_a_d    = pair_addr;
            addr_b_d    = pair_addr + ADDR_W'(1);
            infl_vld1_d = pair_vld1;
            infl_last_d = pair_last;
        end

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = pair_last ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (issue && pair_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && head.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            rem_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            infl_q      <= 1'b0;
            infl_vld1_q <= 1'b0;
            infl_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            infl_q      <= infl_d;
            infl_vld1_q <= infl_vld1_d;
            infl_last_q <= infl_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Capture the pair read last cycle; the odd word of a short final pair
    // is dropped to zero.
    always_comb begin
        cap_beat.data0     = rom_q_a;
        cap_beat.data1     = infl_vld1_q ? rom_q_b : '0;
        cap_beat.data1_vld = infl_vld1_q;
        cap_beat.last      = infl_last_q;
    end

    conv2_fetch_skid u_skid (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (infl_q),
        .push_beat_i (cap_beat),
        .pop_i       (accept),
        .head_o      (head),
        .count_o     (count)
    );

    assign w_valid     = (count != 2'd0);
    assign w_data0     = head.data0;
    assign w_data1     = head.data1;
    assign w_data1_vld = w_valid && head.data1_vld;
    assign w_last      = w_valid && head.last;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv2_kernel_fetch.sv
// Bench for conv2_kernel_fetch: four instances with kernel lengths 25, 8, 1
// and 7 share one clock and reset, each fed by its own registered ROM model
// with rom[i] = 16'h1000 + i.
module tb_conv2_kernel_fetch;

    localparam int N = 4;

    function automatic int kl_of(input int k);
        case (k)
            0:       return 25;
            1:       return 8;
            2:       return 1;
            default: return 7;
        endcase
    endfunction

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset_n;
    logic [N-1:0]        start, busy, done, w_valid, w_ready, w_data1_vld, w_last;
    logic [N-1:0][7:0]   base_addr, rom_addr_a, rom_addr_b;
    logic [N-1:0][15:0]  rom_q_a, rom_q_b, w_data0, w_data1;

    int checks = 0;
    int errors = 0;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            conv2_kernel_fetch #(
                .ADDR_W     (8),
                .DATA_W     (16),
                .KERNEL_LEN (kl_of(g))
            ) u_dut (
                .clock       (clock),
                .reset_n     (reset_n),
                .start       (start[g]),
                .base_addr   (base_addr[g]),
                .busy        (busy[g]),
                .done        (done[g]),
                .rom_addr_a  (rom_addr_a[g]),
                .rom_addr_b  (rom_addr_b[g]),
                .rom_q_a     (rom_q_a[g]),
                .rom_q_b     (rom_q_b[g]),
                .w_valid     (w_valid[g]),
                .w_ready     (w_ready[g]),
                .w_data0     (w_data0[g]),
                .w_data1     (w_data1[g]),
                .w_data1_vld (w_data1_vld[g]),
                .w_last      (w_last[g])
            );
        end
    endgenerate

    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            rom_q_a[i] <= 16'h1000 + {8'h00, rom_addr_a[i]};
            rom_q_b[i] <= 16'h1000 + {8'h00, rom_addr_b[i]};
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Expected beat j of a kernel of length kl starting at b.
    function automatic logic [33:0] exp_beat(input int kl, input int b, input int j);
        logic [15:0] d0, d1;
        logic        v1, last;
        d0   = 16'h1000 + 16'((b + 2 * j) % 256);
        v1   = (2 * j + 1) < kl;
        d1   = v1 ? 16'h1000 + 16'((b + 2 * j + 1) % 256) : 16'h0000;
        last = (j == (kl + 1) / 2 - 1);
        return {d0, d1, v1, last};
    endfunction

    // 0/3: always ready; 1: toggling with a 5-cycle stall; 2: random.
    function automatic logic ready_for(input int mode, input int c);
        if (mode == 1) begin
            if (c >= 8 && c < 13) return 1'b0;
            return (c % 2) == 1;
        end
        if (mode == 2) return $urandom_range(0, 1) == 1;
        return 1'b1;
    endfunction

    // One complete kernel on instance k. Mode 3 pulses start again mid-fetch.
    task automatic run_kernel(input int k, input logic [7:0] b, input int mode);
        int          kl, nb, nacc, last_c, idx;
        logic [33:0] beat, prev_beat;
        logic        prev_valid, prev_ready;
        kl         = kl_of(k);
        nb         = (kl + 1) / 2;
        nacc       = 0;
        last_c     = -1;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_beat  = '0;
        @(posedge clock); #1;
        start[k]     = 1'b1;
        base_addr[k] = b;
        w_ready[k]   = ready_for(mode, 0);
        for (int c = 1; c <= 200; c++) begin
            @(posedge clock); #1;
            start[k]     = (mode == 3) && (c == 4);
            base_addr[k] = 8'($urandom);
            w_ready[k]   = ready_for(mode, c);
            @(negedge clock);
            beat = {w_data0[k], w_data1[k], w_data1_vld[k], w_last[k]};
            if (c == 1) chk("first_gap", 64'(w_valid[k]), 64'd0);
            if (c == 2) chk("first_valid", 64'(w_valid[k]), 64'd1);
            if (prev_valid && !prev_ready)
                chk("stall_hold", {w_valid[k], beat}, {1'b1, prev_beat});
            if (w_valid[k] && w_ready[k]) begin
                if (nacc < nb) chk("beat", beat, exp_beat(kl, b, nacc));
                else           chk("extra_beat", 64'(nacc + 1), 64'(nb));
                nacc++;
                if (nacc == nb) last_c = c;
            end
            idx = ((int'(rom_addr_a[k]) - int'(b)) & 255) >> 1;
            chk("credit", 64'(idx + 1 <= nacc + 2), 64'd1);
            chk("addr_b", 64'(rom_addr_b[k]), 64'(8'(rom_addr_a[k] + 8'd1)));
            chk("done", 64'(done[k]), 64'(last_c >= 0 && c == last_c + 1));
            chk("busy", 64'(busy[k]), 64'(last_c < 0 || c <= last_c));
            prev_valid = w_valid[k];
            prev_ready = w_ready[k];
            prev_beat  = beat;
            if (last_c >= 0 && c == last_c + 1) break;
        end
        chk("beat_count", 64'(nacc), 64'(nb));
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = '0;
        w_ready   = '0;
        base_addr = '0;
        repeat (2) @(negedge clock);
        chk("reset_flags", {busy, done, w_valid, w_last, w_data1_vld}, 64'd0);
        chk("reset_addr", {rom_addr_a, rom_addr_b}, 64'd0);
        chk("reset_data", {w_data0[0], w_data1[0], w_data0[2], w_data1[2]}, 64'd0);
        reset_n = 1'b1;

        run_kernel(0, 8'h00, 0);
        run_kernel(1, 8'hFC, 0);
        run_kernel(0, 8'($urandom), 1);
        run_kernel(0, 8'($urandom), 3);
        run_kernel(0, 8'($urandom), 0);
        run_kernel(2, 8'h00, 0);
        run_kernel(2, 8'($urandom), 2);
        run_kernel(3, 8'hFF, 1);
        for (int i = 0; i < 8; i++) begin
            run_kernel(int'($urandom_range(0, N - 1)), 8'($urandom), 2);
        end

        // Reset in the middle of a stalled fetch.
        @(posedge clock); #1;
        start[0]     = 1'b1;
        base_addr[0] = 8'h40;
        w_ready[0]   = 1'b0;
        @(posedge clock); #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("pre_reset_busy", 64'({busy[0], w_valid[0]}), 64'b11);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {busy[0], done[0], w_valid[0], w_last[0], w_data1_vld[0],
                            rom_addr_a[0], rom_addr_b[0], w_data0[0], w_data1[0]}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_no_done", 64'({done[0], busy[0], w_valid[0]}), 64'd0);
        end
        reset_n    = 1'b1;
        w_ready[0] = 1'b1;
        run_kernel(0, 8'h10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
